// File: rtl/photo_loader.sv
// -----------------------------------------------------------------------------
// photo_loader
//
// Producer side of the hidden layer's flat photo bus. Pixels arrive one per
// cycle over a valid/ready stream and are written into the flat photo vector,
// slot by slot. Once a frame of exactly NUM_PIXELS pixels has been received,
// the vector is held stable with photo_valid high until the consumer
// acknowledges it.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   pix_valid    in   source presents a pixel
//   pix_ready    out  loader accepts a pixel this cycle (decoded from state)
//   pix_data     in   pixel value, DATA_WIDTH bits, unsigned
//   pix_last     in   source marks the final pixel of the frame
//   photo        out  assembled frame; pixel k at [DATA_WIDTH*k +: DATA_WIDTH]
//   photo_valid  out  photo complete and stable
//   photo_ack    in   consumer has taken the photo (only honoured in HOLD)
//   pix_count    out  pixels accepted in the current frame
//   frame_err    out  one-cycle pulse on a frame length mismatch
// -----------------------------------------------------------------------------
module photo_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pix_valid,
    output logic                             pix_ready,
    input  logic [DATA_WIDTH-1:0]            pix_data,
    input  logic                             pix_last,
    output logic [NUM_PIXELS*DATA_WIDTH-1:0] photo,
    output logic                             photo_valid,
    input  logic                             photo_ack,
    output logic [CNT_WIDTH-1:0]             pix_count,
    output logic                             frame_err
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_PIXELS - 1);

    state_t                             state_q, state_d;
    logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic [NUM_PIXELS*DATA_WIDTH-1:0]   photo_q, photo_d;
    logic                               err_q, err_d;
    logic                               xfer;

    // Handshake outputs depend only on registered state, so there is no
    // combinational path from pix_valid or photo_ack to pix_ready.
    assign pix_ready   = (state_q != HOLD);
    assign photo_valid = (state_q == HOLD);
    assign photo       = photo_q;
    assign pix_count   = cnt_q;
    assign frame_err   = err_q;

    assign xfer = pix_valid && pix_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        photo_d = photo_q;
        err_d   = 1'b0;

        unique case (state_q)
            FILL: begin
                if (xfer) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
                        if (pix_last) begin
                            photo_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = pix_data;
                            state_d = HOLD;
                        end else begin
                            // Too many pixels: flag now and swallow the rest.
                            err_d   = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (pix_last) begin
                        // Frame ended early; the slot is not written and the
                        // next pixel starts a fresh frame at slot 0.
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        photo_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = pix_data;
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (xfer && pix_last) begin
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (photo_ack) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            photo_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            photo_q <= photo_d;
            err_q   <= err_d;
        end
    end

endmodule
